// File: rtl/e1_track_pkg.sv
// Shared constants and FSM encoding for the Galileo E1 local-code path.
package e1_track_pkg;

  localparam int          CODE_LENGTH      = 4092;
  localparam int          CODE_LENGTH_LOG2 = 12;
  localparam int          RAM_WORDS        = 128;
  localparam logic [31:0] SYNC_WORD        = 32'h1000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_STREAM = 2'd2
  } stream_state_t;

endpackage

// File: rtl/e1_code_ram.sv
// Packed chip RAM: one write port, one synchronous read port, no reset so it maps to block RAM.
module e1_code_ram #(
  parameter int WORDS = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);
  import e1_track_pkg::*;

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/e1_code_streamer.sv
// Streams one E1 primary code as a sentinel word followed by one chip per AXI-Stream word.
// Optional chip popcount is built when E1_STREAMER_POPCOUNT_EN is defined.
module e1_code_streamer #(
  parameter int          DSIZE            = 32,
  parameter int          CODE_LENGTH      = e1_track_pkg::CODE_LENGTH,
  parameter int          CODE_LENGTH_LOG2 = e1_track_pkg::CODE_LENGTH_LOG2,
  parameter int          RAM_WORDS        = e1_track_pkg::RAM_WORDS,
  parameter logic [31:0] SYNC_WORD        = e1_track_pkg::SYNC_WORD
) (
  input  logic                          axis_aclk,
  input  logic                          axis_areset,
  input  logic                          i_wr_en,
  input  logic [$clog2(RAM_WORDS)-1:0]  i_wr_addr,
  input  logic [31:0]                   i_wr_data,
  input  logic                          i_start,
  input  logic                          i_abort,
  output logic [DSIZE-1:0]              o_code_tdata,
  output logic                          o_code_tvalid,
  input  logic                          i_code_tready,
  output logic                          o_code_tlast,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CODE_LENGTH_LOG2:0]     o_ones_count
);
  import e1_track_pkg::*;

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [CODE_LENGTH_LOG2-1:0] LAST_IDX = CODE_LENGTH_LOG2'(CODE_LENGTH - 1);

  stream_state_t               state, state_next;
  logic [CODE_LENGTH_LOG2-1:0] idx, idx_next;
  logic [AW-1:0]               rd_ptr, rd_ptr_next, rd_addr;
  logic [31:0]                 cur_word, cur_next, rd_data;
  logic [DSIZE-1:0]            tdata_next;
  logic                        tvalid_next, tlast_next, busy_next, done_next;
  logic                        hs, start_ok, ram_we, chip;

  assign hs       = o_code_tvalid && i_code_tready;
  assign start_ok = (state == ST_IDLE) && i_start && !i_abort;
  assign ram_we   = i_wr_en && (state == ST_IDLE);
  // Word 0 is read while idle/sync; in STREAM rd_ptr always addresses the word after cur_word,
  // so the RAM output register doubles as the prefetched next word.
  assign rd_addr  = (state == ST_STREAM) ? rd_ptr : '0;

  e1_code_ram #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
    .clk     (axis_aclk),
    .wr_en   (ram_we),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    rd_ptr_next = rd_ptr;
    cur_next    = cur_word;
    tdata_next  = o_code_tdata;
    tvalid_next = o_code_tvalid;
    tlast_next  = o_code_tlast;
    busy_next   = o_busy;
    done_next   = 1'b0;
    chip        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_next  = ST_SYNC;
          idx_next    = '0;
          rd_ptr_next = '0;
          tdata_next  = DSIZE'(SYNC_WORD);
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
          busy_next   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SYNC, ST_STREAM: begin
        if (i_abort || (hs && o_code_tlast)) begin
          state_next  = ST_IDLE;
          tdata_next  = '0;
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          busy_next   = 1'b0;
          done_next   = !i_abort;
        end else if (hs) begin
          // Leaving sync or crossing a 32-chip boundary pulls the next packed word in.
          if (state == ST_SYNC || idx[4:0] == 5'd31) begin
            cur_next    = rd_data;
            chip        = rd_data[0];
            rd_ptr_next = rd_ptr + AW'(1);
          end else begin
            chip = cur_word[idx[4:0] + 5'd1];
          end
          idx_next    = (state == ST_SYNC) ? '0 : idx + CODE_LENGTH_LOG2'(1);
          state_next  = ST_STREAM;
          tdata_next  = DSIZE'(chip);
          tlast_next  = (idx_next == LAST_IDX);
        end else begin
          state_next = state;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        tdata_next  = '0;
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
        busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      rd_ptr        <= '0;
      cur_word      <= '0;
      o_code_tdata  <= '0;
      o_code_tvalid <= 1'b0;
      o_code_tlast  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      rd_ptr        <= rd_ptr_next;
      cur_word      <= cur_next;
      o_code_tdata  <= tdata_next;
      o_code_tvalid <= tvalid_next;
      o_code_tlast  <= tlast_next;
      o_busy        <= busy_next;
      o_done        <= done_next;
    end
  end

`ifdef E1_STREAMER_POPCOUNT_EN
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      o_ones_count <= '0;
    end else if (start_ok) begin
      o_ones_count <= '0;
    end else if (state == ST_STREAM && hs && o_code_tdata[0]) begin
      o_ones_count <= o_ones_count + (CODE_LENGTH_LOG2 + 1)'(1);
    end else begin
      o_ones_count <= o_ones_count;
    end
  end
`else
  assign o_ones_count = '0;
`endif

endmodule

// File: tb/tb_e1_code_streamer.sv
// Directed scoreboard bench for e1_code_streamer: expected words queued at start, compared as emitted.
module tb_e1_code_streamer;

  logic        axis_aclk = 1'b0;
  logic        axis_areset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [6:0]  i_wr_addr = 7'd0;
  logic [31:0] i_wr_data = 32'd0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_code_tready = 1'b0;
  logic [31:0] o_code_tdata;
  logic        o_code_tvalid, o_code_tlast, o_busy, o_done;
  logic [12:0] o_ones_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [128];
  logic [32:0] sbq [$];

  e1_code_streamer dut (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .i_wr_en       (i_wr_en),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .o_code_tdata  (o_code_tdata),
    .o_code_tvalid (o_code_tvalid),
    .i_code_tready (i_code_tready),
    .o_code_tlast  (o_code_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_ones_count  (o_ones_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tvalid"}, o_code_tvalid, 0);
    check({tag, "_tdata"},  o_code_tdata, 0);
    check({tag, "_tlast"},  o_code_tlast, 0);
    check({tag, "_busy"},   o_busy, 0);
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    i_wr_en = 1'b1; i_wr_addr = 7'(addr); i_wr_data = data;
    mem[addr] = data;
    tick();
    i_wr_en = 1'b0;
  endtask

  // mode: 0 full run, 1 abort at chip stop_at, 2 reset at chip stop_at, 3 write+start poke while busy
  task automatic run_stream(input int mode, input int stop_at, input bit rnd, input int ones_req);
    int          exp_ones = 0;
    int          n_pop = 0;
    int          cyc = 0;
    logic [32:0] popped;
    bit          rdy;
    sbq.delete();
    sbq.push_back({1'b0, 32'h1000_0000});
    for (int k = 0; k < 4092; k++) begin
      sbq.push_back({(k == 4091), 31'd0, mem[k / 32][k % 32]});
      exp_ones += int'(mem[k / 32][k % 32]);
    end
    if (ones_req >= 0) exp_ones = ones_req;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (sbq.size() > 0) begin
      if (cyc >= 20000) begin
        check("stream_timeout", cyc, 0);
        return;
      end
      cyc++;
      if ((mode == 1 || mode == 2) && n_pop == stop_at + 1) begin
        i_code_tready = 1'b1;
        if (mode == 1) i_abort = 1'b1; else axis_areset = 1'b1;
        tick();
        i_abort = 1'b0;
        axis_areset = 1'b0;
        check_quiet(mode == 1 ? "abort" : "reset");
        check("stop_done", o_done, 0);
        if (mode == 2) check("reset_ones", o_ones_count, 0);
        tick();
        check("stop_done_later", o_done, 0);
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_code_tready = rdy;
      if (mode == 3 && n_pop == 50) begin
        i_wr_en = 1'b1; i_wr_addr = 7'd3; i_wr_data = ~mem[3]; i_start = 1'b1;
      end
      check("tvalid", o_code_tvalid, 1);
      check("word", {o_code_tlast, o_code_tdata}, sbq[0]);
      check("busy_done", {o_busy, o_done}, 2'b10);
      if (rdy) begin
        popped = sbq.pop_front();
        n_pop++;
      end
      tick();
      i_wr_en = 1'b0;
      i_start = 1'b0;
    end
    check("done_pulse", o_done, 1);
    check_quiet("after_last");
`ifdef E1_STREAMER_POPCOUNT_EN
    check("ones_count", o_ones_count, 13'(exp_ones));
`else
    check("ones_count", o_ones_count, 0);
`endif
    tick();
    check("done_single", o_done, 0);
  endtask

  initial begin
    for (int w = 0; w < 128; w++) mem[w] = 32'd0;
    tick();
    tick();
    axis_areset = 1'b0;
    check_quiet("reset");
    check("reset_done", o_done, 0);
    check("reset_ones", o_ones_count, 0);

    for (int w = 0; w < 128; w++) wr(w, 32'hAAAA_AAAA);
    i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    check_quiet("start_abort_idle");
    tick();
    check("start_abort_idle_tvalid", o_code_tvalid, 0);

    run_stream(0, 0, 1'b0, 2046);

    for (int w = 0; w < 128; w++) wr(w, $urandom());
    run_stream(0, 0, 1'b1, -1);

    for (int w = 0; w < 127; w++) wr(w, 32'd0);
    wr(127, 32'hFFFF_FFFF);
    run_stream(0, 0, 1'b0, 28);

    for (int w = 0; w < 128; w++) wr(w, $urandom());
    run_stream(1, 100, 1'b0, -1);
    run_stream(0, 0, 1'b0, -1);

    run_stream(3, 0, 1'b0, -1);
    run_stream(0, 0, 1'b1, -1);

    run_stream(2, 2000, 1'b0, -1);
    run_stream(0, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
